// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one EEPROM controller between requesters A and B.
// Holds the command for CMD_CYCLES, then waits for the matching END or a timeout.
module eeprom_arbiter #(
  parameter int          CMD_CYCLES = 4,
  parameter logic [15:0] TIMEOUT    = 16'd4000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_A,
  input  logic        REQ_B,
  input  logic        WE_A,
  input  logic        WE_B,
  input  logic [10:0] ADDR_A,
  input  logic [10:0] ADDR_B,
  input  logic [7:0]  WDATA_A,
  input  logic [7:0]  WDATA_B,
  output logic        ACK_A,
  output logic        ACK_B,
  output logic        ERR_A,
  output logic        ERR_B,
  output logic [7:0]  RDATA_A,
  output logic [7:0]  RDATA_B,
  output logic        BUSY,
  output logic        EE_RD,
  output logic        EE_WR,
  output logic [10:0] EE_ADDR,
  inout  wire  [7:0]  EE_DATA,
  input  logic        EE_RD_END,
  input  logic        EE_WR_END
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] CMD_LAST = 16'(CMD_CYCLES - 1);

  logic [1:0]  state;
  logic        owner;
  logic        last;
  logic        we;
  logic        ok;
  logic [7:0]  wdata;
  logic [15:0] cnt;
  logic        grant_b;
  logic        end_ok;

  // owner/last: 0 = A, 1 = B; on a tie the port that did not go last wins
  assign grant_b = REQ_B & (~REQ_A | ~last);
  assign end_ok  = we ? EE_WR_END : EE_RD_END;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      we      <= 1'b0;
      ok      <= 1'b0;
      wdata   <= 8'h00;
      cnt     <= 16'h0000;
      EE_ADDR <= 11'h000;
      RDATA_A <= 8'h00;
      RDATA_B <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (REQ_A | REQ_B) begin
            owner   <= grant_b;
            last    <= grant_b;
            we      <= grant_b ? WE_B : WE_A;
            EE_ADDR <= grant_b ? ADDR_B : ADDR_A;
            wdata   <= grant_b ? WDATA_B : WDATA_A;
            cnt     <= 16'h0000;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == CMD_LAST) begin
            cnt   <= 16'h0000;
            state <= WAIT;
          end else begin
            cnt <= cnt + 16'h0001;
          end
        end
        WAIT: begin
          if (end_ok) begin
            ok    <= 1'b1;
            state <= DONE;
            if (!we) begin
              if (owner) RDATA_B <= EE_DATA;
              else       RDATA_A <= EE_DATA;
            end
          end else if (cnt == TIMEOUT) begin
            ok    <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 16'h0001;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY    = (state != IDLE);
  assign EE_RD   = (state == ISSUE) & ~we;
  assign EE_WR   = (state == ISSUE) & we;
  assign ACK_A   = (state == DONE) & ok & ~owner;
  assign ACK_B   = (state == DONE) & ok & owner;
  assign ERR_A   = (state == DONE) & ~ok & ~owner;
  assign ERR_B   = (state == DONE) & ~ok & owner;
  assign EE_DATA = (BUSY & we) ? wdata : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter with a tiny EEPROM controller stand-in.
// The bench drives EE_DATA itself to check that the arbiter leaves it released.
module tb_eeprom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, we_a, we_b;
  logic [10:0] addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        ack_a, ack_b, err_a, err_b;
  logic [7:0]  rdata_a, rdata_b;
  logic        busy, ee_rd, ee_wr;
  logic [10:0] ee_addr;
  wire  [7:0]  ee_data;
  logic        rd_end, wr_end;
  logic        drv;
  logic [7:0]  mdata;

  int pass_cnt = 0;
  int total = 0;

  assign ee_data = drv ? mdata : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  eeprom_arbiter #(.CMD_CYCLES(4), .TIMEOUT(16'd50)) dut (
    .CLK(clk), .RESET(reset),
    .REQ_A(req_a), .REQ_B(req_b),
    .WE_A(we_a), .WE_B(we_b),
    .ADDR_A(addr_a), .ADDR_B(addr_b),
    .WDATA_A(wdata_a), .WDATA_B(wdata_b),
    .ACK_A(ack_a), .ACK_B(ack_b),
    .ERR_A(err_a), .ERR_B(err_b),
    .RDATA_A(rdata_a), .RDATA_B(rdata_b),
    .BUSY(busy), .EE_RD(ee_rd), .EE_WR(ee_wr),
    .EE_ADDR(ee_addr), .EE_DATA(ee_data),
    .EE_RD_END(rd_end), .EE_WR_END(wr_end)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    rd_end = 0; wr_end = 0; drv = 0; mdata = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if ({busy, ee_rd, ee_wr, ack_a, ack_b, err_a, err_b} !== 7'b0)
      $display("FAIL reset_ctl got %b exp 0",
               {busy, ee_rd, ee_wr, ack_a, ack_b, err_a, err_b});
    else pass_cnt++;
    total++;
    if ({rdata_a, rdata_b, ee_addr} !== 27'h0)
      $display("FAIL reset_regs got %h/%h/%h exp 0", rdata_a, rdata_b, ee_addr);
    else pass_cnt++;
    drv = 1; mdata = 8'h3C; #1;
    total++;
    if (ee_data !== 8'h3C) $display("FAIL reset_z got %h exp 3c", ee_data);
    else pass_cnt++;
    drv = 0;
    reset = 1'b0;
  endtask

  task automatic test_read_a();
    int strobes = 0;
    int addr_bad = 0;
    req_a = 1; we_a = 0; addr_a = 11'h2A5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) req_a = 1;
      addr_a = 11'h111;
      if (ee_rd) strobes++;
      if (ee_wr || !busy || ee_addr !== 11'h2A5) addr_bad++;
    end
    total++;
    if (strobes !== 4) $display("FAIL rd_strobe got %0d exp 4", strobes);
    else pass_cnt++;
    total++;
    if (addr_bad !== 0) $display("FAIL rd_issue got %0d bad cycles exp 0", addr_bad);
    else pass_cnt++;
    repeat (29) tick();
    rd_end = 1; drv = 1; mdata = 8'h5C;
    tick();
    rd_end = 0; drv = 0; req_a = 0;
    total++;
    if ({ack_a, ack_b, err_a, err_b} !== 4'b1000)
      $display("FAIL rd_ack got %b exp 1000", {ack_a, ack_b, err_a, err_b});
    else pass_cnt++;
    total++;
    if (rdata_a !== 8'h5C || rdata_b !== 8'h00)
      $display("FAIL rd_data got %h/%h exp 5c/00", rdata_a, rdata_b);
    else pass_cnt++;
    tick();
    total++;
    if (ack_a !== 1'b0 || busy !== 1'b0)
      $display("FAIL rd_idle got ack %b busy %b exp 0 0", ack_a, busy);
    else pass_cnt++;
  endtask

  task automatic test_write_b();
    int strobes = 0;
    int bad = 0;
    req_b = 1; we_b = 1; addr_b = 11'h7FF; wdata_b = 8'hA3;
    for (int c = 1; c <= 5; c++) begin
      tick();
      addr_b = 11'h000; wdata_b = 8'h00;
      if (ee_wr) strobes++;
      if (ee_rd || ee_data !== 8'hA3 || ee_addr !== 11'h7FF) bad++;
    end
    total++;
    if (strobes !== 4) $display("FAIL wr_strobe got %0d exp 4", strobes);
    else pass_cnt++;
    total++;
    if (bad !== 0) $display("FAIL wr_hold got %0d bad cycles exp 0", bad);
    else pass_cnt++;
    repeat (3) tick();
    wr_end = 1;
    tick();
    wr_end = 0; req_b = 0;
    total++;
    if ({ack_a, ack_b, err_a, err_b} !== 4'b0100 || ee_data !== 8'hA3)
      $display("FAIL wr_ack got %b data %h exp 0100 a3",
               {ack_a, ack_b, err_a, err_b}, ee_data);
    else pass_cnt++;
    total++;
    if (rdata_b !== 8'h00 || rdata_a !== 8'h5C)
      $display("FAIL wr_rdata got %h/%h exp 5c/00", rdata_a, rdata_b);
    else pass_cnt++;
    tick();
    drv = 1; mdata = 8'h5C; #1;
    total++;
    if (ee_data !== 8'h5C) $display("FAIL wr_release got %h exp 5c", ee_data);
    else pass_cnt++;
    drv = 0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_addr;
    logic        exp_b;
    int          n;
    do_reset();
    req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    addr_a = 11'h011; addr_b = 11'h022;
    for (int t = 0; t < 4; t++) begin
      exp_b = t[0];
      exp_addr = exp_b ? 11'h022 : 11'h011;
      n = 0;
      while (!ee_rd && n < 10) begin tick(); n++; end
      total++;
      if (ee_addr !== exp_addr)
        $display("FAIL rr_grant%0d got %h exp %h", t, ee_addr, exp_addr);
      else pass_cnt++;
      n = 0;
      while (ee_rd && n < 10) begin tick(); n++; end
      rd_end = 1; drv = 1; mdata = 8'h10 + 8'(t);
      tick();
      rd_end = 0; drv = 0;
      total++;
      if ({ack_a, ack_b} !== {~exp_b, exp_b} ||
          (exp_b ? rdata_b : rdata_a) !== 8'h10 + 8'(t))
        $display("FAIL rr_ack%0d got %b/%h exp %b/%h", t, {ack_a, ack_b},
                 exp_b ? rdata_b : rdata_a, {~exp_b, exp_b}, 8'h10 + 8'(t));
      else pass_cnt++;
    end
    req_a = 0; req_b = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    int acks = 0;
    do_reset();
    req_a = 1; we_a = 0; addr_a = 11'h055;
    tick();
    while (ee_rd && n < 10) begin tick(); n++; end
    n = 0;
    while (!err_a && n < 100) begin
      tick();
      n++;
      if (ack_a || ack_b) acks++;
    end
    req_a = 0;
    total++;
    if (n !== 51) $display("FAIL to_latency got %0d exp 51", n);
    else pass_cnt++;
    total++;
    if (acks !== 0 || err_b !== 1'b0 || rdata_a !== 8'h00)
      $display("FAIL to_noack got acks %0d errb %b rd %h exp 0 0 00",
               acks, err_b, rdata_a);
    else pass_cnt++;
    tick();
    total++;
    if (busy !== 1'b0 || err_a !== 1'b0)
      $display("FAIL to_idle got busy %b err %b exp 0 0", busy, err_a);
    else pass_cnt++;
  endtask

  task automatic test_wrong_end();
    int strobes = 0;
    do_reset();
    req_a = 1; we_a = 0; addr_a = 11'h0AA;
    tick();
    if (ee_rd) strobes++;
    rd_end = 1; drv = 1; mdata = 8'hEE;
    tick();
    if (ee_rd) strobes++;
    rd_end = 0; drv = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ee_rd) strobes++;
    end
    total++;
    if (strobes !== 4 || ee_rd !== 1'b0 || busy !== 1'b1)
      $display("FAIL early_end got strobes %0d rd %b busy %b exp 4 0 1",
               strobes, ee_rd, busy);
    else pass_cnt++;
    wr_end = 1; drv = 1; mdata = 8'hEE;
    tick();
    wr_end = 0; drv = 0;
    total++;
    if (ack_a !== 1'b0 || err_a !== 1'b0 || busy !== 1'b1)
      $display("FAIL wrong_end got ack %b err %b busy %b exp 0 0 1",
               ack_a, err_a, busy);
    else pass_cnt++;
    repeat (3) tick();
    rd_end = 1; drv = 1; mdata = 8'h77;
    tick();
    rd_end = 0; drv = 0; req_a = 0;
    total++;
    if (ack_a !== 1'b1 || rdata_a !== 8'h77)
      $display("FAIL valid_end got ack %b rd %h exp 1 77", ack_a, rdata_a);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    req_a = 1; we_a = 1; addr_a = 11'h123; wdata_a = 8'h55;
    tick();
    while (ee_wr && n < 10) begin tick(); n++; end
    repeat (3) tick();
    reset = 1;
    tick();
    total++;
    if ({busy, ee_rd, ee_wr, ack_a, ack_b, err_a, err_b} !== 7'b0 ||
        ee_addr !== 11'h000)
      $display("FAIL mid_reset got %b addr %h exp 0 000",
               {busy, ee_rd, ee_wr, ack_a, ack_b, err_a, err_b}, ee_addr);
    else pass_cnt++;
    drv = 1; mdata = 8'h5C; #1;
    total++;
    if (ee_data !== 8'h5C) $display("FAIL mid_reset_z got %h exp 5c", ee_data);
    else pass_cnt++;
    drv = 0;
    reset = 0; req_a = 0;
    req_b = 1; we_b = 0; addr_b = 11'h3C3;
    tick();
    tick();
    total++;
    if (ee_rd !== 1'b1 || ee_addr !== 11'h3C3)
      $display("FAIL post_reset_b got rd %b addr %h exp 1 3c3", ee_rd, ee_addr);
    else pass_cnt++;
    repeat (5) tick();
    rd_end = 1;
    tick();
    rd_end = 0; req_b = 0;
    total++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0)
      $display("FAIL post_reset_ack got %b exp 10", {ack_b, ack_a});
    else pass_cnt++;
    tick();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_read_a();
    test_write_b();
    test_back_to_back();
    test_timeout();
    test_wrong_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
